// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle for alu_exec_unit.
// The upstream stage uses the master view; the execution unit uses the slave view.
interface alu_exec_unit_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   aluctr;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         err;

    modport master (
        output in_valid, aluop, funct, a, b, out_ready,
        input  in_ready, out_valid, aluctr, result, result_hi, zero, err
    );

    modport slave (
        input  in_valid, aluop, funct, a, b, out_ready,
        output in_ready, out_valid, aluctr, result, result_hi, zero, err
    );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes aluop/funct, runs single-cycle ops in one cycle and
// unsigned multiply/divide iteratively over W cycles behind a valid/ready handshake.
module alu_exec_unit #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [3:0] CTR_AND   = 4'b0000;
    localparam logic [3:0] CTR_OR    = 4'b0001;
    localparam logic [3:0] CTR_ADD   = 4'b0010;
    localparam logic [3:0] CTR_SUB   = 4'b0110;
    localparam logic [3:0] CTR_SLT   = 4'b0111;
    localparam logic [3:0] CTR_NOR   = 4'b1100;
    localparam logic [3:0] CTR_MULTU = 4'b1000;
    localparam logic [3:0] CTR_DIVU  = 4'b1001;
    localparam logic [3:0] CTR_ILL   = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [3:0] decode(input logic [2:0] op, input logic [5:0] fn);
        logic [3:0] c;
        case (op)
            3'b000:  c = CTR_ADD;
            3'b001:  c = CTR_SUB;
            3'b010:  c = CTR_AND;
            3'b011:  c = CTR_OR;
            3'b101:  c = CTR_SLT;
            3'b100: begin
                case (fn)
                    6'b100000: c = CTR_ADD;
                    6'b100010: c = CTR_SUB;
                    6'b100100: c = CTR_AND;
                    6'b100101: c = CTR_OR;
                    6'b100111: c = CTR_NOR;
                    6'b101010: c = CTR_SLT;
                    6'b011001: c = CTR_MULTU;
                    6'b011011: c = CTR_DIVU;
                    default:   c = CTR_ILL;
                endcase
            end
            default: c = CTR_ILL;
        endcase
        return c;
    endfunction

    // Low result of every op that finishes at the accept edge; divu here is only ever divide-by-zero.
    function automatic logic [W-1:0] alu_single(input logic [3:0] c, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        logic signed [W-1:0] xs;
        logic signed [W-1:0] ys;
        logic [W-1:0]        r;
        xs = x;
        ys = y;
        case (c)
            CTR_ADD:  r = x + y;
            CTR_SUB:  r = x - y;
            CTR_AND:  r = x & y;
            CTR_OR:   r = x | y;
            CTR_NOR:  r = ~(x | y);
            CTR_SLT:  r = {{(W-1){1'b0}}, (xs < ys)};
            CTR_DIVU: r = '1;
            default:  r = '0;
        endcase
        return r;
    endfunction

    state_t        st;
    logic [CW-1:0] cnt;
    logic          in_ready_r, out_valid_r, zero_r, err_r;
    logic [3:0]    aluctr_r;
    logic [W-1:0]  result_r, result_hi_r;

    logic [W-1:0]  acc_hi, acc_lo, opnd_b;
    logic          is_div;

    logic [3:0]    ctr_in;
    logic          multi_go;
    logic [W-1:0]  one_lo, one_hi;
    logic          one_err;
    logic [W:0]    mul_sum, div_sh, div_sub;
    logic          div_ge;
    logic [W-1:0]  nxt_hi, nxt_lo;

    assign ctr_in   = decode(bus.aluop, bus.funct);
    assign multi_go = (st == IDLE) && bus.in_valid &&
                      ((ctr_in == CTR_MULTU) || ((ctr_in == CTR_DIVU) && (bus.b != '0)));

    always_comb begin
        one_lo  = alu_single(ctr_in, bus.a, bus.b);
        one_hi  = (ctr_in == CTR_DIVU) ? bus.a : '0;
        one_err = (ctr_in == CTR_ILL) || (ctr_in == CTR_DIVU);
    end

    // Multiply: shift-add with the multiplier in acc_lo; divide: restoring, quotient shifts into acc_lo.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
        div_sh  = {acc_hi, acc_lo[W-1]};
        div_ge  = div_sh >= {1'b0, opnd_b};
        div_sub = div_sh - {1'b0, opnd_b};
        if (is_div) begin
            nxt_hi = div_ge ? div_sub[W-1:0] : div_sh[W-1:0];
            nxt_lo = {acc_lo[W-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[W:1];
            nxt_lo = {mul_sum[0], acc_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (multi_go) begin
            acc_hi <= '0;
            acc_lo <= bus.a;
            opnd_b <= bus.b;
            is_div <= (ctr_in == CTR_DIVU);
        end else if (st == BUSY) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            aluctr_r    <= 4'b0000;
            result_r    <= '0;
            result_hi_r <= '0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        aluctr_r   <= ctr_in;
                        if (multi_go) begin
                            st  <= BUSY;
                            cnt <= CW'(W);
                        end else begin
                            st          <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= one_lo;
                            result_hi_r <= one_hi;
                            zero_r      <= (one_lo == '0);
                            err_r       <= one_err;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        st          <= DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= nxt_lo;
                        result_hi_r <= nxt_hi;
                        zero_r      <= (nxt_lo == '0);
                        err_r       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        st          <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.aluctr    = aluctr_r;
    assign bus.result    = result_r;
    assign bus.result_hi = result_hi_r;
    assign bus.zero      = zero_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit at W=8 against an arithmetic reference model.
module tb_alu_exec_unit;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_exec_unit_if #(.W(W)) bus ();

    alu_exec_unit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: sim time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: control code, results, error flag and latency straight from the operation table.
    task automatic model(input logic [2:0] op, input logic [5:0] fn, input logic [7:0] av,
                         input logic [7:0] bv, output logic [3:0] ctr, output logic [7:0] r,
                         output logic [7:0] h, output logic e, output int lat);
        logic [15:0] p;
        case (op)
            3'd0: ctr = 4'h2;
            3'd1: ctr = 4'h6;
            3'd2: ctr = 4'h0;
            3'd3: ctr = 4'h1;
            3'd5: ctr = 4'h7;
            3'd4: begin
                case (fn)
                    6'h20: ctr = 4'h2;
                    6'h22: ctr = 4'h6;
                    6'h24: ctr = 4'h0;
                    6'h25: ctr = 4'h1;
                    6'h27: ctr = 4'hC;
                    6'h2A: ctr = 4'h7;
                    6'h19: ctr = 4'h8;
                    6'h1B: ctr = 4'h9;
                    default: ctr = 4'hF;
                endcase
            end
            default: ctr = 4'hF;
        endcase
        r = 8'h00; h = 8'h00; e = 1'b0; lat = 1;
        case (ctr)
            4'h2: r = av + bv;
            4'h6: r = av - bv;
            4'h0: r = av & bv;
            4'h1: r = av | bv;
            4'hC: r = ~(av | bv);
            4'h7: r = ($signed(av) < $signed(bv)) ? 8'd1 : 8'd0;
            4'h8: begin
                p = {8'h00, av} * {8'h00, bv};
                r = p[7:0]; h = p[15:8]; lat = W + 1;
            end
            4'h9: begin
                if (bv == 8'h00) begin
                    e = 1'b1; r = 8'hFF; h = av;
                end else begin
                    r = av / bv; h = av % bv; lat = W + 1;
                end
            end
            default: e = 1'b1;
        endcase
    endtask

    // Presents one op at a negedge, scrambles inputs after the accept edge, and checks the response.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [5:0] fn,
                          input logic [7:0] av, input logic [7:0] bv, input int stall,
                          input bit noise);
        logic [3:0] ec;
        logic [7:0] er, eh;
        logic       ee;
        int         el, lat;
        model(op, fn, av, bv, ec, er, eh, ee, el);
        check({nm, "_in_ready_idle"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.aluop     = op;
        bus.funct     = fn;
        bus.a         = av;
        bus.b         = bv;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.aluop    = 3'($urandom);
        bus.funct    = 6'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check({nm, "_in_ready_busy"}, bus.in_ready, 0);
            if (noise) bus.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check({nm, "_latency"}, lat, el);
        check({nm, "_out_valid"}, bus.out_valid, 1);
        check({nm, "_aluctr"}, bus.aluctr, ec);
        check({nm, "_result"}, bus.result, er);
        check({nm, "_result_hi"}, bus.result_hi, eh);
        check({nm, "_zero"}, bus.zero, (er == 8'h00));
        check({nm, "_err"}, bus.err, ee);
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check({nm, "_hold_valid"}, bus.out_valid, 1);
            check({nm, "_hold_in_ready"}, bus.in_ready, 0);
            check({nm, "_hold_result"}, {bus.result_hi, bus.result, bus.aluctr, bus.zero, bus.err},
                  {eh, er, ec, (er == 8'h00), ee});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_release_valid"}, bus.out_valid, 0);
        check({nm, "_release_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        logic [5:0] legal_fn [8];
        logic [5:0] fn;
        logic [7:0] av, bv;
        bit         seen;
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h19, 6'h1B};
        bus.in_valid  = 1'b0;
        bus.aluop     = 3'd0;
        bus.funct     = 6'd0;
        bus.a         = 8'd0;
        bus.b         = 8'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_outputs", {bus.out_valid, bus.aluctr, bus.result, bus.result_hi, bus.zero, bus.err},
              '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sub_rtype", 3'b100, 6'h22, 8'h05, 8'h07, 0, 0);
        run_op("slt_neg",   3'b101, 6'h00, 8'hFF, 8'h01, 0, 0);
        run_op("multu_max", 3'b100, 6'h19, 8'hFF, 8'hFF, 0, 1);
        run_op("divu_200_7", 3'b100, 6'h1B, 8'd200, 8'd7, 0, 0);
        run_op("divu_by0",  3'b100, 6'h1B, 8'd9, 8'd0, 0, 0);
        run_op("divu_zero_num", 3'b100, 6'h1B, 8'd0, 8'd13, 0, 0);
        run_op("ill_funct", 3'b100, 6'h08, 8'h12, 8'h34, 0, 0);
        run_op("ill_op7",   3'b111, 6'h20, 8'h56, 8'h78, 0, 0);
        run_op("sub_stall", 3'b001, 6'h00, 8'h33, 8'h33, 5, 0);
        run_op("nor_after", 3'b100, 6'h27, 8'h0F, 8'h30, 0, 0);

        for (int i = 0; i < 80; i++) begin
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: av = 8'h00;
                1: av = 8'hFF;
                default: av = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: bv = 8'h00;
                1: bv = 8'hFF;
                default: bv = 8'($urandom);
            endcase
            run_op("rand", 3'($urandom_range(0, 7)), fn, av, bv, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a multiply: the op must vanish without a result.
        bus.in_valid = 1'b1;
        bus.aluop    = 3'b100;
        bus.funct    = 6'h19;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_outputs", {bus.out_valid, bus.aluctr, bus.result, bus.result_hi, bus.zero, bus.err},
              '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("midreset_no_stale_valid", seen, 0);
        run_op("post_reset_add", 3'b000, 6'h00, 8'hF0, 8'h20, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
